os_array_ctrl: RTL and testbench
================================

Name: os_array_ctrl

Overview:
Sequencer for an N x N output-stationary systolic array built from OSPE tiles. On a start command it clears the array's partial sums and pipeline registers, then issues skewed A-row and B-column feed enables and operand buffer addresses for K_LEN inner-product steps. It then flushes the wavefront through the array and steps a row select so the psum outputs can be drained. It sits between the command/operand-buffer logic and the array, and drives the array's active-low rstnPipe/rstnPsum inputs.

Parameters:
N, 4, array dimension (rows = columns = N), 2..16
K_MAX, 16, maximum inner dimension accepted
AW, $clog2(K_MAX), operand buffer address width per row/column
KW, $clog2(K_MAX+1), width of k_len

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  command strobe; sampled only in IDLE
k_len  in  KW  inner dimension for this command; sampled with start
busy  out  1  high from CLEAR through DONE inclusive
done  out  1  one-cycle pulse in DONE
err  out  1  valid with done; 1 = k_len illegal, nothing executed
pipe_clr_n  out  1  to array rstnPipe, active-low
psum_clr_n  out  1  to array rstnPsum, active-low
row_en  out  N  bit i: feed A row i from buffer this cycle; 0 = feed zero
col_en  out  N  bit j: feed B column j from buffer this cycle; 0 = feed zero
a_addr  out  N*AW  flattened; slice i = A buffer address for row i
b_addr  out  N*AW  flattened; slice j = B buffer address for column j
drain_valid  out  1  drain_row is valid this cycle
drain_row  out  $clog2(N)  array row whose opC values are presented for capture

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE; busy, done, err, row_en, col_en, drain_valid = 0; addresses and drain_row = 0.
- pipe_clr_n and psum_clr_n are 0 while rst is high, so the array is held cleared. Both read 1 from the first IDLE cycle after reset.
- States: IDLE -> CLEAR -> FEED -> FLUSH -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 with 1 <= k_len <= K_MAX: latch k_len and go to CLEAR next cycle.
  - start=1 with k_len = 0 or k_len > K_MAX: go to DONE with err=1, skipping all other states.
  - start=0: remain in IDLE.
- start is ignored in every state other than IDLE. The IDLE-to-CLEAR step costs one cycle, so busy rises the cycle after start.
- CLEAR, 1 cycle: pipe_clr_n = 0 and psum_clr_n = 0.
- FEED, K+N-1 cycles, step counter t = 0..K+N-2:
  - row_en[i] = (i <= t < i+K); a_addr slice i = t-i when enabled, else 0.
  - col_en[j] and b_addr slice j follow the same rule with j.
- FLUSH, N-1 cycles: row_en = col_en = 0, clears deasserted, wavefront propagates.
- DRAIN, N cycles: drain_valid = 1; drain_row = 0..N-1, incrementing by 1 per cycle.
- DONE, 1 cycle: done = 1, busy = 1, err as decided in IDLE; back to IDLE next cycle.
- Outside CLEAR, pipe_clr_n and psum_clr_n are 1 in every state. psum values therefore persist after DONE until the next command's CLEAR.
- Legal command busy duration: 1 + (K+N-1) + (N-1) + N + 1 = K + 3N cycles.
- Error command: busy is high for exactly 1 cycle (DONE).
- rst asserted in any state: the next edge returns the block to IDLE with reset values. The in-flight command is discarded and no done is issued.
- start held high continuously: the next command is accepted in the first IDLE cycle after DONE.
- Counters are sized so t never wraps for k_len = K_MAX.

Optional Feature:
- Macro: OS_ARRAY_CTRL_PERF_EN.
- When defined:
  - Adds output perf_cycles, 32 bits, reset 0.
  - An internal counter clears on CLEAR entry and increments every cycle busy=1.
  - perf_cycles is updated with the final count in the DONE cycle and holds it until the next DONE.
  - An error command loads 1.
  - The counter saturates at 2^32-1.
- When undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset (N=4): hold rst 2 cycles -> all outputs 0, including pipe_clr_n and psum_clr_n. Release -> both clears 1, busy 0.
- Legal command (N=4): start with k_len=3 ->
  - CLEAR one cycle with both clears 0.
  - FEED 6 cycles with row_en = 0001, 0011, 0111, 1110, 1100, 1000; a_addr row 3 = 0, 1, 2 at t = 3, 4, 5. col_en matches row_en.
  - FLUSH 3 cycles, then drain_row 0, 1, 2, 3, then done=1, err=0.
  - busy high exactly 15 cycles.
- Illegal k_len: start with k_len=0, then with k_len=17 -> each gives busy high 1 cycle, done=1, err=1, no clear pulse, row_en stays 0.
- Mid-run reset and start while busy:
  - Pulse start during FEED -> ignored; sequence length unchanged.
  - Assert rst at FEED t=2 -> next cycle IDLE, no done, row_en=0.
  - A new start with k_len=1 then completes in 13 cycles.
- Boundary and back-to-back: k_len=K_MAX=16 -> FEED 19 cycles, a_addr row 0 reaches 15, no counter wrap. Hold start high -> second command's CLEAR begins the cycle after the first returns to IDLE.
- With OS_ARRAY_CTRL_PERF_EN defined: k_len=3 -> perf_cycles=15 at DONE. Following error command -> perf_cycles=1.

Source files
------------

// File: rtl/os_array_ctrl.sv
// -----------------------------------------------------------------------------
// os_array_ctrl
//   Sequencer for an N x N output-stationary systolic array of OSPE tiles.
//   A command runs through these states:
//     CLEAR  resets the array's pipeline and psum registers.
//     FEED   issues skewed A-row / B-column feed enables and buffer addresses.
//     FLUSH  lets the wavefront finish propagating.
//     DRAIN  steps a row select so the psums can be captured.
//     DONE   pulses done.
//   An illegal k_len goes straight to DONE with err set.
//
// Optional feature (macro OS_ARRAY_CTRL_PERF_EN):
//   Adds perf_cycles, which holds the busy-cycle count of the last command.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   start        command strobe, sampled only in IDLE
//   k_len        inner dimension, sampled with start
//   busy         high from CLEAR through DONE
//   done         one-cycle pulse in DONE
//   err          valid with done; 1 = k_len illegal, nothing executed
//   pipe_clr_n   array rstnPipe (active-low)
//   psum_clr_n   array rstnPsum (active-low)
//   row_en       per-row A feed enable
//   col_en       per-column B feed enable
//   a_addr       flattened per-row A buffer addresses (AW bits each)
//   b_addr       flattened per-column B buffer addresses (AW bits each)
//   drain_valid  drain_row is valid
//   drain_row    row whose psums are presented for capture
//   perf_cycles  (OS_ARRAY_CTRL_PERF_EN only) busy cycles of last command
// -----------------------------------------------------------------------------
module os_array_ctrl #(
  parameter int N     = 4,
  parameter int K_MAX = 16,
  parameter int AW    = $clog2(K_MAX),
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  pipe_clr_n,
  output logic                  psum_clr_n,
  output logic [N-1:0]          row_en,
  output logic [N-1:0]          col_en,
  output logic [N*AW-1:0]       a_addr,
  output logic [N*AW-1:0]       b_addr,
  output logic                  drain_valid,
  output logic [$clog2(N)-1:0]  drain_row
`ifdef OS_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int DRW = $clog2(N);
  // Step counter must reach K_MAX+N-2 without wrapping.
  localparam int CW  = $clog2(K_MAX + 2 * N + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic            cmd_err_q, cmd_err_d;

  // Registered outputs and their next values
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            clr_n_q, clr_n_d;
  logic [N-1:0]    row_en_q, row_en_d;
  logic [N-1:0]    col_en_q, col_en_d;
  logic [N*AW-1:0] a_addr_q, a_addr_d;
  logic [N*AW-1:0] b_addr_q, b_addr_d;
  logic            dv_q, dv_d;
  logic [DRW-1:0]  drain_row_q, drain_row_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    cmd_err_d = cmd_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((k_len == '0) || (k_len > KW'(K_MAX))) begin
            state_d   = S_DONE;
            cmd_err_d = 1'b1;
          end else begin
            state_d   = S_CLEAR;
            k_d       = k_len;
            cmd_err_d = 1'b0;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        // Last feed step is t = K+N-2 (lane N-1 consumes its final operand).
        if (cnt_q == CW'(k_q) + CW'(N - 2)) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (cnt_q == CW'(N - 2)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the next state so that the registered outputs
  // line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_DONE) && cmd_err_d;
    clr_n_d     = (state_d != S_CLEAR);
    dv_d        = (state_d == S_DRAIN);
    drain_row_d = (state_d == S_DRAIN) ? DRW'(cnt_d) : '0;
  end

  // Per-lane skew: lane gi is fed during steps gi .. gi+K-1 with address t-gi.
  // Rows and columns share the same schedule.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      localparam logic [CW-1:0] LANE = CW'(gi);
      logic          lane_en;
      logic [AW-1:0] lane_addr;

      always_comb begin
        lane_en   = (state_d == S_FEED) && (cnt_d >= LANE) &&
                    (cnt_d < LANE + CW'(k_q));
        lane_addr = AW'(cnt_d - LANE);
      end

      assign row_en_d[gi]           = lane_en;
      assign col_en_d[gi]           = lane_en;
      assign a_addr_d[gi*AW +: AW]  = lane_en ? lane_addr : '0;
      assign b_addr_d[gi*AW +: AW]  = lane_en ? lane_addr : '0;
    end
  endgenerate

  // Output registers. While rst is high the clears are held active (0).
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      clr_n_q     <= 1'b0;
      row_en_q    <= '0;
      col_en_q    <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      dv_q        <= 1'b0;
      drain_row_q <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      clr_n_q     <= clr_n_d;
      row_en_q    <= row_en_d;
      col_en_q    <= col_en_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      dv_q        <= dv_d;
      drain_row_q <= drain_row_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign pipe_clr_n  = clr_n_q;
  assign psum_clr_n  = clr_n_q;
  assign row_en      = row_en_q;
  assign col_en      = col_en_q;
  assign a_addr      = a_addr_q;
  assign b_addr      = b_addr_q;
  assign drain_valid = dv_q;
  assign drain_row   = drain_row_q;

`ifdef OS_ARRAY_CTRL_PERF_EN
  // Running count of busy cycles for the current command; it restarts at 1
  // on leaving IDLE so the first busy cycle (CLEAR, or DONE for an error)
  // is included. It is published when DONE is entered.
  logic [31:0] perf_cnt_q, perf_cnt_d;
  logic [31:0] perf_cycles_q;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
      perf_cnt_d = 32'd1;
    end else if ((state_d != S_IDLE) && (perf_cnt_q != '1)) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_q    <= '0;
      perf_cycles_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
      if (state_d == S_DONE) begin
        perf_cycles_q <= perf_cnt_d;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_os_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_os_array_ctrl
//   Scoreboard bench for os_array_ctrl (N=4, K_MAX=16). Each command pushes
//   its expected cycle-by-cycle output frames into a queue. Frames are popped
//   and compared once per cycle, #1 after the rising edge.
// -----------------------------------------------------------------------------
module tb_os_array_ctrl;

  localparam int N     = 4;
  localparam int K_MAX = 16;
  localparam int AW    = 4;
  localparam int KW    = 5;
  localparam int DRW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy, done, err, pipe_clr_n, psum_clr_n, drain_valid;
  logic [N-1:0]    row_en, col_en;
  logic [N*AW-1:0] a_addr, b_addr;
  logic [DRW-1:0]  drain_row;
`ifdef OS_ARRAY_CTRL_PERF_EN
  logic [31:0]     perf_cycles;
`endif

  os_array_ctrl #(.N(N), .K_MAX(K_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .k_len       (k_len),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .pipe_clr_n  (pipe_clr_n),
    .psum_clr_n  (psum_clr_n),
    .row_en      (row_en),
    .col_en      (col_en),
    .a_addr      (a_addr),
    .b_addr      (b_addr),
    .drain_valid (drain_valid),
    .drain_row   (drain_row)
`ifdef OS_ARRAY_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              busy;
    bit              done;
    bit              err;
    bit              clr_n;
    logic [N-1:0]    row;
    logic [N-1:0]    col;
    logic [N*AW-1:0] a;
    logic [N*AW-1:0] b;
    bit              dv;
    logic [DRW-1:0]  dr;
    logic [31:0]     perf;
  } frame_t;

  frame_t      exp_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int unsigned perf_model = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t idle_frame();
    frame_t f;
    f.busy  = 0; f.done = 0; f.err = 0; f.clr_n = 1;
    f.row   = '0; f.col = '0; f.a = '0; f.b = '0;
    f.dv    = 0; f.dr = '0;
    f.perf  = perf_model;
    return f;
  endfunction

  // Build the expected frame sequence of one command.
  task automatic push_cmd(input int k);
    frame_t f;
    if (k < 1 || k > K_MAX) begin
      f = idle_frame();
      f.busy = 1; f.done = 1; f.err = 1; f.perf = 1;
      exp_q.push_back(f);
      perf_model = 1;
    end else begin
      f = idle_frame(); f.busy = 1; f.clr_n = 0;
      exp_q.push_back(f);
      for (int t = 0; t <= k + N - 2; t++) begin
        f = idle_frame(); f.busy = 1;
        for (int i = 0; i < N; i++) begin
          if (i <= t && t < i + k) begin
            f.row[i] = 1'b1;
            f.col[i] = 1'b1;
            f.a[i*AW +: AW] = AW'(t - i);
            f.b[i*AW +: AW] = AW'(t - i);
          end
        end
        exp_q.push_back(f);
      end
      for (int s = 0; s < N - 1; s++) begin
        f = idle_frame(); f.busy = 1;
        exp_q.push_back(f);
      end
      for (int d = 0; d < N; d++) begin
        f = idle_frame(); f.busy = 1; f.dv = 1; f.dr = DRW'(d);
        exp_q.push_back(f);
      end
      f = idle_frame(); f.busy = 1; f.done = 1; f.perf = 32'(k + 3 * N);
      exp_q.push_back(f);
      perf_model = 32'(k + 3 * N);
    end
  endtask

  task automatic cmp_frame(input frame_t f, input string where);
    check_val({"busy@", where}, busy, f.busy);
    check_val({"done@", where}, done, f.done);
    check_val({"err@", where}, err, f.err);
    check_val({"pipe_clr_n@", where}, pipe_clr_n, f.clr_n);
    check_val({"psum_clr_n@", where}, psum_clr_n, f.clr_n);
    check_val({"row_en@", where}, row_en, f.row);
    check_val({"col_en@", where}, col_en, f.col);
    check_val({"a_addr@", where}, a_addr, f.a);
    check_val({"b_addr@", where}, b_addr, f.b);
    check_val({"drain_valid@", where}, drain_valid, f.dv);
    check_val({"drain_row@", where}, drain_row, f.dr);
`ifdef OS_ARRAY_CTRL_PERF_EN
    check_val({"perf_cycles@", where}, perf_cycles, f.perf);
`endif
  endtask

  task automatic cmp_reset_frame(input string where);
    frame_t f;
    f = idle_frame();
    f.clr_n = 0;
    f.perf  = 0;
    cmp_frame(f, where);
  endtask

  // Drive start with k_len for one edge and queue the expected frames.
  // With keep set, start stays high afterwards.
  task automatic issue(input int k, input bit keep);
    start = 1'b1;
    k_len = KW'(k);
    push_cmd(k);
    tick();
    if (!keep) start = 1'b0;
  endtask

  // Pop and compare frames until the queue drains.
  //   inject_at >= 0 : drive start=1 (k_len=5) on that frame only, else 0.
  //   rst_at    >= 0 : assert rst after that frame and abandon the command.
  task automatic consume(input string name, input int inject_at,
                         input int rst_at, input int exp_busy);
    int nb = 0;
    int i  = 0;
    bit aborted = 0;
    while (exp_q.size() > 0) begin
      frame_t f;
      if (inject_at >= 0) begin
        start = (i == inject_at);
        if (i == inject_at) k_len = KW'(5);
      end
      if (busy) nb++;
      f = exp_q.pop_front();
      cmp_frame(f, $sformatf("%s[%0d]", name, i));
      if (i == rst_at) begin
        rst = 1'b1;
        tick();
        exp_q.delete();
        perf_model = 0;
        cmp_reset_frame({name, "_rst"});
        rst = 1'b0;
        tick();
        cmp_frame(idle_frame(), {name, "_post_rst"});
        aborted = 1;
        break;
      end
      tick();
      i++;
    end
    if (inject_at >= 0) start = 1'b0;
    if (!aborted) check_val({name, "_busy_cycles"}, nb, exp_busy);
    $display("cmd %s: busy_cycles=%0d aborted=%0d", name, nb, aborted);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    k_len = '0;

    // Reset: held two cycles, then released.
    tick();
    tick();
    cmp_reset_frame("reset");
    rst = 1'b0;
    tick();
    cmp_frame(idle_frame(), "after_reset");

    // Legal command k=3.
    issue(3, 0);
    consume("k3", -1, -1, 3 + 3 * N);
    cmp_frame(idle_frame(), "idle_k3");

    // Illegal k_len values.
    issue(0, 0);
    consume("k0", -1, -1, 1);
    cmp_frame(idle_frame(), "idle_k0");
    issue(17, 0);
    consume("k17", -1, -1, 1);
    cmp_frame(idle_frame(), "idle_k17");

    // start pulsed during FEED is ignored.
    issue(2, 0);
    consume("k2_inject", 3, -1, 2 + 3 * N);
    cmp_frame(idle_frame(), "idle_k2");

    // Reset during FEED t=2 (frame 3), then a fresh k=1 command.
    issue(3, 0);
    consume("k3_rst", -1, 3, 0);
    issue(1, 0);
    consume("k1", -1, -1, 1 + 3 * N);
    cmp_frame(idle_frame(), "idle_k1");

    // K_MAX with start held high: the second command follows one IDLE cycle.
    issue(K_MAX, 1);
    k_len = KW'(2);
    consume("kmax", -1, -1, K_MAX + 3 * N);
    cmp_frame(idle_frame(), "idle_kmax");
    push_cmd(2);
    tick();
    start = 1'b0;
    consume("k2_b2b", -1, -1, 2 + 3 * N);
    cmp_frame(idle_frame(), "idle_b2b");

    // Perf readback: legal then error command.
    issue(3, 0);
    consume("k3_perf", -1, -1, 3 + 3 * N);
    issue(0, 0);
    consume("k0_perf", -1, -1, 1);
    cmp_frame(idle_frame(), "idle_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
